// File: rtl/assemblatore_parole_pkg.sv
// Shared types and constants for the message word assembler.
package assemblatore_pkg;

   localparam int BYTES_PER_WORD  = 4;
   localparam int WORDS_PER_BLOCK = 16;
   localparam int NUM_BLOCKS      = 8;
   localparam int MEM_DEPTH       = 512;
   localparam int ADDR_W          = 9;
   localparam int BYTE_W          = 8;
   localparam int WORD_W          = BYTES_PER_WORD * BYTE_W;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LAST,
      OUT,
      DONE
   } stato_t;

endpackage

// File: rtl/assemblatore_parole_impacchettatore.sv
// Byte-to-word shift packer. Default build places the first byte in the
// most significant lane (big-endian); defining LITTLE_ENDIAN_EN places it
// in the least significant lane instead.
module impacchettatore
   import assemblatore_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cattura,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] parola
);

   // Shift one memory byte into the word each capture cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parola <= '0;
      end else if (cattura) begin
`ifdef LITTLE_ENDIAN_EN
         parola <= {byte_in, parola[WORD_W-1:BYTE_W]};
`else
         parola <= {parola[WORD_W-BYTE_W-1:0], byte_in};
`endif
      end
   end

endmodule

// File: rtl/assemblatore_parole.sv
// Reads a 512-byte message one byte per cycle and presents it as 128
// 32-bit words (8 blocks of 16) over a valid/ready handshake.
// Optional build macro: LITTLE_ENDIAN_EN selects little-endian packing.
module assemblatore_parole
   import assemblatore_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              re,
   output logic [ADDR_W-1:0] indirizzo_read,
   input  logic [BYTE_W-1:0] out_mem,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [3:0]        word_idx,
   output logic [2:0]        block_idx,
   output logic              last_word_of_block,
   output logic              last_block,
   output logic              busy,
   output logic              done
);

   stato_t            stato_q, stato_d;
   logic [1:0]        byte_cnt;
   logic [ADDR_W-1:0] addr;
   logic              cattura;
   logic              ultima_parola;

   assign ultima_parola = (word_idx  == 4'(WORDS_PER_BLOCK - 1)) &&
                          (block_idx == 3'(NUM_BLOCKS - 1));

   assign indirizzo_read     = addr;
   assign last_word_of_block = word_valid && (word_idx  == 4'(WORDS_PER_BLOCK - 1));
   assign last_block         = word_valid && (block_idx == 3'(NUM_BLOCKS - 1));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stato_q <= IDLE;
      else        stato_q <= stato_d;
   end

   // Next state and per-state outputs. Read data lags re by one cycle, so
   // FETCH captures bytes 0..2 on its 2nd..4th cycles and LAST takes byte 3.
   always_comb begin
      stato_d    = stato_q;
      re         = 1'b0;
      word_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      cattura    = 1'b0;
      case (stato_q)
         IDLE: begin
            if (start) stato_d = FETCH;
         end
         FETCH: begin
            re      = 1'b1;
            busy    = 1'b1;
            cattura = (byte_cnt != 2'd0);
            if (byte_cnt == 2'(BYTES_PER_WORD - 1)) stato_d = LAST;
         end
         LAST: begin
            busy    = 1'b1;
            cattura = 1'b1;
            stato_d = OUT;
         end
         OUT: begin
            busy       = 1'b1;
            word_valid = 1'b1;
            if (word_ready) stato_d = ultima_parola ? DONE : FETCH;
         end
         DONE: begin
            done = 1'b1;
            if (start) stato_d = FETCH;
         end
         default: stato_d = IDLE;
      endcase
   end

   // Address, byte and word/block counters. The address holds at the last
   // byte so that finishing the message never points back at address 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr      <= '0;
         byte_cnt  <= '0;
         word_idx  <= '0;
         block_idx <= '0;
      end else begin
         case (stato_q)
            IDLE, DONE: begin
               if (start) begin
                  addr      <= '0;
                  byte_cnt  <= '0;
                  word_idx  <= '0;
                  block_idx <= '0;
               end
            end
            FETCH: begin
               byte_cnt <= byte_cnt + 2'd1;
               if (addr != ADDR_W'(MEM_DEPTH - 1)) addr <= addr + 1'b1;
            end
            OUT: begin
               if (word_ready) begin
                  word_idx <= word_idx + 4'd1;
                  if (word_idx == 4'(WORDS_PER_BLOCK - 1)) block_idx <= block_idx + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   impacchettatore u_impacchettatore (
      .clk     (clk),
      .reset   (reset),
      .cattura (cattura),
      .byte_in (out_mem),
      .parola  (word_out)
   );

endmodule

// File: tb/tb_assemblatore_parole.sv
// Self-checking bench for assemblatore_parole: memory holds ram[i] = i mod 256,
// expected words are queued at each start and compared on every handshake.
module tb_assemblatore_parole;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        re;
   logic [8:0]  indirizzo_read;
   logic [7:0]  out_mem;
   logic [31:0] word_out;
   logic        word_valid;
   logic        word_ready;
   logic [3:0]  word_idx;
   logic [2:0]  block_idx;
   logic        last_word_of_block;
   logic        last_block;
   logic        busy;
   logic        done;

   typedef struct packed {
      logic [31:0] w;
      logic [3:0]  wi;
      logic [2:0]  bi;
      logic        lw;
      logic        lb;
   } atteso_t;

   atteso_t sb[$];
   atteso_t e_mon;

   int n_check = 0;
   int n_err   = 0;
   int n_re    = 0;
   int n_acc   = 0;
   int letture  [0:511];
   int base_let [0:511];
   int base_re;
   int base_acc;

   always #5 clk = ~clk;

   assemblatore_parole dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .re                 (re),
      .indirizzo_read     (indirizzo_read),
      .out_mem            (out_mem),
      .word_out           (word_out),
      .word_valid         (word_valid),
      .word_ready         (word_ready),
      .word_idx           (word_idx),
      .block_idx          (block_idx),
      .last_word_of_block (last_word_of_block),
      .last_block         (last_block),
      .busy               (busy),
      .done               (done)
   );

   task automatic chk(input string tag, input logic [63:0] oss, input logic [63:0] att);
      n_check++;
      if (oss !== att) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, oss, att);
      end
   endtask

   function automatic logic [31:0] parola_attesa(input int n);
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'((4 * n + 0) % 256);
      b1 = 8'((4 * n + 1) % 256);
      b2 = 8'((4 * n + 2) % 256);
      b3 = 8'((4 * n + 3) % 256);
`ifdef LITTLE_ENDIAN_EN
      return {b3, b2, b1, b0};
`else
      return {b0, b1, b2, b3};
`endif
   endfunction

   function automatic logic [63:0] uscite();
      return {10'b0, re, indirizzo_read, word_out, word_valid, word_idx, block_idx,
              last_word_of_block, last_block, busy, done};
   endfunction

   // Synchronous memory: data one cycle after re, junk otherwise.
   always @(posedge clk) out_mem <= re ? indirizzo_read[7:0] : 8'h5A;

   // Count read cycles and reads per address.
   always @(posedge clk) begin
      if (reset && re) begin
         n_re <= n_re + 1;
         letture[indirizzo_read] <= letture[indirizzo_read] + 1;
      end
   end

   // Scoreboard: compare each accepted word against the queue head.
   always @(negedge clk) begin
      if (reset && word_valid && word_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_word", 64'd1, 64'd0);
         end else begin
            e_mon = sb.pop_front();
            chk("word_out",           word_out,           e_mon.w);
            chk("word_idx",           word_idx,           e_mon.wi);
            chk("block_idx",          block_idx,          e_mon.bi);
            chk("last_word_of_block", last_word_of_block, e_mon.lw);
            chk("last_block",         last_block,         e_mon.lb);
         end
         n_acc++;
      end
   end

   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   task automatic avvia();
      atteso_t a;
      for (int n = 0; n < 128; n++) begin
         a.w  = parola_attesa(n);
         a.wi = 4'(n % 16);
         a.bi = 3'(n / 16);
         a.lw = ((n % 16) == 15);
         a.lb = ((n / 16) == 7);
         sb.push_back(a);
      end
      base_re  = n_re;
      base_let = letture;
      base_acc = n_acc;
      start = 1'b1;
      ciclo();
      start = 1'b0;
   endtask

   task automatic attendi_done(input string tag);
      int k = 0;
      while (!done && k < 3000) begin
         ciclo();
         k++;
      end
      chk(tag, done, 1);
   endtask

   task automatic verifica_run();
      int errati = 0;
      for (int i = 0; i < 512; i++)
         if (letture[i] - base_let[i] != 1) errati++;
      chk("re_pulses",   n_re - base_re, 512);
      chk("addr_once",   errati, 0);
      chk("queue_empty", sb.size(), 0);
      chk("busy_done",   busy, 0);
   endtask

   initial begin
      int k;
      logic [8:0] frz;
      reset      = 1'b0;
      start      = 1'b0;
      word_ready = 1'b1;
      repeat (3) ciclo();
      chk("reset_state", uscite(), 64'd0);
      reset = 1'b1;
      ciclo();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);

      // Run 1: continuous ready.
      avvia();
      attendi_done("run1_done");
      verifica_run();

      // Run 2: start during FETCH ignored, stall at word 5.
      avvia();
      k = 0;
      while (!(re && indirizzo_read == 9'd2) && k < 50) begin ciclo(); k++; end
      chk("reach_fetch", indirizzo_read, 9'd2);
      start = 1'b1;
      ciclo();
      start = 1'b0;
      chk("busy_fetch", busy, 1);
      k = 0;
      while (!(re && indirizzo_read == 9'd20) && k < 200) begin ciclo(); k++; end
      chk("reach_word5", indirizzo_read, 9'd20);
      word_ready = 1'b0;
      k = 0;
      while (!word_valid && k < 20) begin ciclo(); k++; end
      frz = indirizzo_read;
      for (int c = 0; c < 10; c++) begin
         chk("stall_word",  word_out, parola_attesa(5));
         chk("stall_valid", word_valid, 1);
         chk("stall_re",    re, 0);
         chk("stall_addr",  indirizzo_read, frz);
         ciclo();
      end
      word_ready = 1'b1;
      attendi_done("run2_done");
      verifica_run();

      // Run 3: start from DONE, then reset after word 40.
      avvia();
      chk("restart_done", done, 0);
      chk("restart_busy", busy, 1);
      chk("restart_re",   re, 1);
      chk("restart_addr", indirizzo_read, 9'd0);
      k = 0;
      while ((n_acc - base_acc) < 41 && k < 600) begin ciclo(); k++; end
      chk("reach_word40", n_acc - base_acc, 41);
      reset = 1'b0;
      #1;
      chk("reset_mid_run", uscite(), 64'd0);
      sb.delete();
      repeat (3) ciclo();
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         ciclo();
         chk("no_partial_word", word_valid, 0);
      end

      // Run 4: full run after reset.
      avvia();
      attendi_done("run4_done");
      verifica_run();

      $display("Simulation finished: %0d checks, %0d errors", n_check, n_err);
      $finish;
   end

endmodule

// File: doc/assemblatore_parole.md
ASSEMBLATORE_PAROLE -- requirements
Module: assemblatore_parole

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed below (clock and reset first).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 start  input  1  single-cycle request to read and pack the full 512-byte message.
REQ-005 re  output  1  memory read enable.
REQ-006 indirizzo_read  output  9  memory byte address.
REQ-007 out_mem  input  8  memory read data, valid the cycle after re=1.
REQ-008 word_out  output  32  packed message word.
REQ-009 word_valid  output  1  word_out valid.
REQ-010 word_ready  input  1  consumer accepts word_out when word_valid=1 and word_ready=1.
REQ-011 word_idx  output  4  word index within the current 64-byte block, 0..15.
REQ-012 block_idx  output  3  block index, 0..7.
REQ-013 last_word_of_block  output  1  high with word_valid when word_idx=15.
REQ-014 last_block  output  1  high with word_valid when block_idx=7.
REQ-015 busy  output  1  high in every state except IDLE and DONE.
REQ-016 done  output  1  level, high in DONE.

Function
REQ-017 The FSM SHALL use states IDLE, FETCH, LAST, OUT and DONE.
REQ-018 IDLE or DONE with start=1 SHALL go to FETCH, clear done, zero the byte address and zero both word and block counters.
REQ-019 FETCH SHALL assert re=1 with indirizzo_read=current address for exactly 4 consecutive cycles (byte 0..3 of the word), incrementing the address each cycle.
REQ-020 The byte returned on out_mem SHALL be captured one cycle after its re cycle, and LAST SHALL capture byte 3 with re=0.
REQ-021 Without the Configuration macro, byte 0 SHALL occupy word_out[31:24] and byte 3 word_out[7:0] (big-endian, as SHA-256 requires).
REQ-022 OUT SHALL hold word_valid=1 with word_out, word_idx, block_idx and the last_* flags stable, and re=0, until the cycle word_ready=1.
REQ-023 On acceptance in OUT, word_valid SHALL drop the next cycle, word_idx SHALL increment, and the FSM SHALL return to FETCH.
REQ-024 On word_idx wrap 15->0, block_idx SHALL increment.
REQ-025 Acceptance of word 127 (block 7, word 15) SHALL go to DONE without wrapping indirizzo_read to a new read; minimum cost is 6 cycles per word.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 word_ready outside OUT SHALL have no effect.
REQ-028 Every byte address 0..511 SHALL be read exactly once per run.

Reset
REQ-029 reset=0 SHALL immediately force IDLE and drive every output to 0: re, indirizzo_read, word_out, word_valid, word_idx, block_idx, last_*, busy and done.
REQ-030 Reset mid-run SHALL abandon the run, with no partial word ever presented afterwards.

Configuration
REQ-031 With LITTLE_ENDIAN_EN defined, byte 0 SHALL occupy word_out[7:0] and byte 3 word_out[31:24]; without it, REQ-021 applies, and all other behaviour SHALL be identical in both builds.

Structure
REQ-032 Package assemblatore_pkg SHALL hold the FSM state typedef and the constants BYTES_PER_WORD=4, WORDS_PER_BLOCK=16, NUM_BLOCKS=8, MEM_DEPTH=512 and ADDR_W=9.
REQ-033 Sub-module impacchettatore (byte-to-word shift packer, with the endianness selected by LITTLE_ENDIAN_EN) SHALL be the only sub-module.

Verification
REQ-034 Memory model with ram[i]=i mod 256, start, word_ready=1 -> first word 0x00010203 with idx 0/0, word 127 = 0xFCFDFEFF with last_word_of_block=1 and last_block=1, done=1, exactly 512 re pulses.
REQ-035 word_ready=0 for 10 cycles at word 5 -> word_out stable at 0x14151617, word_valid held, re=0, indirizzo_read frozen.
REQ-036 reset=0 asserted after word 40 -> all outputs 0 the same cycle; a new start restarts at address 0 and first word 0x00010203.
REQ-037 start pulsed during FETCH -> ignored; start in DONE -> done=0 the next cycle and a new run from address 0.
REQ-038 Build with LITTLE_ENDIAN_EN -> first word 0x03020100; last_word_of_block high at words 15, 31, ... 127 only.
